// File: rtl/and_tt_checker.sv
// Exhaustive truth-table checker for a 2-input AND (or NAND) gate under test.
// Optional FAIL_CAPTURE_EN macro records the first mismatching vector and its z value.
module and_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned INVERT_EXP    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic       fail_z
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_a, r_b, r_done, r_pass;
  logic [2:0] r_err;
  logic       w_exp, w_mis, w_accept;

  assign w_exp    = (r_a & r_b) ^ INVERT_EXP[0];
  assign w_mis    = (z != w_exp);
  assign w_accept = (r_state == StIdle) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_d = StDrive;
      StDrive:  w_state_d = StSettle;
      StSettle: if (r_cnt <= 4'd1) w_state_d = StSample;
      StSample: w_state_d = (r_vec == 2'b11) ? StDone : StDrive;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= 2'b00;
      r_cnt  <= 4'd0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= 3'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_vec  <= 2'b00;
            r_err  <= 3'd0;
            r_pass <= 1'b0;
          end
        end
        StDrive: begin
          {r_a, r_b} <= r_vec;
          r_cnt      <= 4'(SETTLE_CYCLES);
        end
        StSettle: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        StSample: begin
          if (w_mis) r_err <= r_err + 3'd1;
          if (r_vec != 2'b11) r_vec <= r_vec + 2'd1;
          else                {r_a, r_b} <= 2'b00;
        end
        StDone: begin
          r_done <= 1'b1;
          r_pass <= (r_err == 3'd0);
        end
        default: ;
      endcase
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign busy    = (r_state == StDrive) || (r_state == StSettle) || (r_state == StSample);
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;

`ifdef FAIL_CAPTURE_EN
  logic [1:0] r_fail_vec;
  logic       r_fail_z;

  // err_cnt is still zero exactly at the first mismatch of a pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_vec <= 2'b00;
      r_fail_z   <= 1'b0;
    end else if (w_accept) begin
      r_fail_vec <= 2'b00;
      r_fail_z   <= 1'b0;
    end else if ((r_state == StSample) && w_mis && (r_err == 3'd0)) begin
      r_fail_vec <= {r_a, r_b};
      r_fail_z   <= z;
    end
  end

  assign fail_vec = r_fail_vec;
  assign fail_z   = r_fail_z;
`else
  logic w_unused;
  assign w_unused = w_accept;
  assign fail_vec = 2'b00;
  assign fail_z   = 1'b0;
`endif

endmodule

// File: doc/and_tt_checker.md
AND_TT_CHECKER -- requirements
Module: and_tt_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles a vector is held before the gate output is sampled; legal range 1..15.
REQ-002 Parameter INVERT_EXP, default 0: 0 expects z = a AND b; 1 expects z = NOT(a AND b).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to run one truth-table pass; sampled only in IDLE.
REQ-006 z  in  1  output of the gate under test, driven from a and b.
REQ-007 a  out  1  registered gate input A.
REQ-008 b  out  1  registered gate input B.
REQ-009 busy  out  1  high in every state except IDLE and DONE.
REQ-010 done  out  1  one-cycle pulse marking the end of a pass.
REQ-011 pass  out  1  1 when the last completed pass had zero mismatches; held until the next start is accepted.
REQ-012 err_cnt  out  3  mismatch count for the current or last pass, range 0..4.
REQ-013 fail_vec  out  2  {a,b} of the first mismatching vector (see REQ-029).
REQ-014 fail_z  out  1  z value captured at the first mismatch (see REQ-029).

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE, all state registered.
REQ-016 IDLE with start=1 SHALL transition to DRIVE and clear vec to 00, err_cnt to 0 and pass to 0; with start=0 it SHALL remain in IDLE.
REQ-017 DRIVE SHALL register {a,b}=vec, load the settle counter with SETTLE_CYCLES and transition to SETTLE.
REQ-018 SETTLE SHALL decrement the counter and transition to SAMPLE after exactly SETTLE_CYCLES cycles.
REQ-019 SAMPLE SHALL compare z against expected = (a&b)^INVERT_EXP and increment err_cnt on mismatch.
REQ-020 SAMPLE with vec!=11 SHALL increment vec and transition to DRIVE; with vec==11 it SHALL transition to DONE.
REQ-021 The vector order SHALL be 00, 01, 10, 11, with vec={a,b}.
REQ-022 DONE SHALL assert done for exactly one cycle, set pass=(err_cnt==0) including the final-sample result, and transition to IDLE unconditionally.
REQ-023 done SHALL assert exactly 4*(SETTLE_CYCLES+2)+1 cycles after the edge on which start was accepted.
REQ-024 start asserted outside IDLE SHALL be ignored; start held high continuously SHALL restart a pass every 4*(SETTLE_CYCLES+2)+2 cycles.
REQ-025 a and b SHALL be 0 in IDLE and DONE and SHALL stay stable between DRIVE and the end of SAMPLE.
REQ-026 err_cnt SHALL not wrap; 4 mismatches is the maximum reachable value and fits in 3 bits.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE and a, b, busy, done, pass, err_cnt, fail_vec, fail_z and vec to 0, independent of clk.
REQ-028 Reset mid-pass SHALL abandon the pass without asserting done; the first start after rst_n rises SHALL run a complete pass from vector 00.

Configuration
REQ-029 With FAIL_CAPTURE_EN defined, the first mismatch of a pass SHALL load fail_vec={a,b} and fail_z=z; later mismatches SHALL not overwrite them, and accepting start SHALL clear both. Without FAIL_CAPTURE_EN, fail_vec and fail_z SHALL be constant 0 and no capture registers SHALL exist.

Verification (clk period 10, gate model delay 1 time unit)
REQ-030 Correct AND gate, SETTLE_CYCLES=4, start pulse: {a,b} steps 00,01,10,11 -> done 25 cycles after start; pass=1, err_cnt=0.
REQ-031 z stuck at 1: err_cnt=3, pass=0; with the macro defined, fail_vec=00 and fail_z=1.
REQ-032 z stuck at 0: err_cnt=1, pass=0; with the macro defined, fail_vec=11 and fail_z=0.
REQ-033 INVERT_EXP=1 with a correct AND gate: err_cnt=4, pass=0.
REQ-034 rst_n pulsed low during SETTLE of vector 10: all outputs 0 at once with no done; a subsequent start yields pass=1 after 25 cycles.
REQ-035 start held high for 60 cycles: done pulses at cycles 25 and 51, and start pulses during busy cause no extra pass.
